key_debounce_mc: RTL and testbench

- Parametrised multi-channel successor to the single-key debouncer used in the spi_ce design.
- Synchronises CH raw mechanical key inputs and debounces each one independently.
- Emits per-channel events: stable level, press pulse, release pulse, long-press pulse and auto-repeat pulses.
- Sits between board pins and control logic, e.g. the multiboot trigger and SPI command FSMs.

---
 rtl/key_debounce_mc_if.sv | 24 ++
 rtl/key_debounce_mc.sv | 165 ++++++++++++++++
 tb/tb_key_debounce_mc.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_mc_if.sv
// Key debouncer bus: raw key levels in, per-channel debounced level and
// event pulses out. Clock and reset stay as plain ports on the block.
interface key_debounce_mc_if #(
  parameter int CH = 4
);
  logic [CH-1:0] key_i;
  logic [CH-1:0] key_state_o;
  logic [CH-1:0] press_o;
  logic [CH-1:0] release_o;
  logic [CH-1:0] long_o;
  logic [CH-1:0] repeat_o;

  // Board/control side: drives the raw keys and consumes the events.
  modport master (
    output key_i,
    input  key_state_o, press_o, release_o, long_o, repeat_o
  );

  // Debouncer side.
  modport slave (
    input  key_i,
    output key_state_o, press_o, release_o, long_o, repeat_o
  );
endinterface

// File: rtl/key_debounce_mc.sv
// Multi-channel key debouncer. Each channel is synchronised, normalised to a
// "pressed" bit and run through its own four-state debounce FSM with a hold
// counter that produces long-press and auto-repeat pulses. All outputs are
// registered, and at most one event pulse per channel is high in any cycle.
module key_debounce_mc #(
  parameter int CH       = 4,
  parameter int DEB_CNT  = 500000,
  parameter int LONG_CNT = 50000000,
  parameter int REP_CNT  = 10000000,
  parameter bit ACT_LOW  = 1'b1,
  parameter bit REP_EN   = 1'b1
) (
  input logic              sclk,
  input logic              rst,
  key_debounce_mc_if.slave bus
);

  localparam int DW   = $clog2(DEB_CNT + 1);
  localparam int HMAX = (LONG_CNT > REP_CNT) ? LONG_CNT : REP_CNT;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CNT - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REP_CNT - 1);
  // Raw pin level of a released key; the synchroniser resets to it so that a
  // key held through reset is seen as a fresh press.
  localparam logic [CH-1:0] REL_LVL   = {CH{ACT_LOW}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    P_DEB = 2'd1,
    HELD  = 2'd2,
    R_DEB = 2'd3
  } state_t;

  logic [CH-1:0] sync1_q;
  logic [CH-1:0] sync2_q;
  logic [CH-1:0] pressed;

  state_t        state_q [CH];
  logic [DW-1:0] dcnt_q  [CH];
  logic [HW-1:0] hcnt_q  [CH];
  logic [CH-1:0] rep_q;      // 1 = long pulse already given, now in repeat phase
  logic [CH-1:0] level_q;
  logic [CH-1:0] press_q;
  logic [CH-1:0] release_q;
  logic [CH-1:0] long_q;
  logic [CH-1:0] repeat_q;

  // Two-flop synchroniser for the asynchronous key pins.
  always_ff @(posedge sclk) begin
    if (rst) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= bus.key_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ACT_LOW ? ~sync2_q : sync2_q;

  // Per-channel debounce FSM with hold counter and registered event pulses.
  always_ff @(posedge sclk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= IDLE;
        dcnt_q[i]  <= '0;
        hcnt_q[i]  <= '0;
      end
      rep_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < CH; i++) begin
        case (state_q[i])
          IDLE: begin
            if (pressed[i]) begin
              state_q[i] <= P_DEB;
              dcnt_q[i]  <= DW'(1);
            end
          end
          P_DEB: begin
            if (!pressed[i]) begin
              state_q[i] <= IDLE;
              dcnt_q[i]  <= '0;
            end else if (dcnt_q[i] == DEB_LAST) begin
              state_q[i] <= HELD;
              dcnt_q[i]  <= '0;
              hcnt_q[i]  <= '0;
              rep_q[i]   <= 1'b0;
              level_q[i] <= 1'b1;
              press_q[i] <= 1'b1;
            end else begin
              dcnt_q[i] <= dcnt_q[i] + DW'(1);
            end
          end
          HELD: begin
            // The hold count only advances while the key is still seen
            // pressed; a release candidate freezes it.
            if (!pressed[i]) begin
              state_q[i] <= R_DEB;
              dcnt_q[i]  <= DW'(1);
            end else if (!rep_q[i]) begin
              if (hcnt_q[i] == LONG_LAST) begin
                hcnt_q[i] <= '0;
                rep_q[i]  <= 1'b1;
                long_q[i] <= 1'b1;
              end else begin
                hcnt_q[i] <= hcnt_q[i] + HW'(1);
              end
            end else if (REP_EN) begin
              if (hcnt_q[i] == REP_LAST) begin
                hcnt_q[i]   <= '0;
                repeat_q[i] <= 1'b1;
              end else begin
                hcnt_q[i] <= hcnt_q[i] + HW'(1);
              end
            end else begin
              // Repeat disabled: park the counter instead of letting it wrap.
              hcnt_q[i] <= hcnt_q[i];
            end
          end
          R_DEB: begin
            if (pressed[i]) begin
              // Bounce back: resume holding with the hold count untouched.
              state_q[i] <= HELD;
              dcnt_q[i]  <= '0;
            end else if (dcnt_q[i] == DEB_LAST) begin
              state_q[i]   <= IDLE;
              dcnt_q[i]    <= '0;
              hcnt_q[i]    <= '0;
              rep_q[i]     <= 1'b0;
              level_q[i]   <= 1'b0;
              release_q[i] <= 1'b1;
            end else begin
              dcnt_q[i] <= dcnt_q[i] + DW'(1);
            end
          end
          default: begin
            state_q[i] <= IDLE;
            dcnt_q[i]  <= '0;
            hcnt_q[i]  <= '0;
            rep_q[i]   <= 1'b0;
            level_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.key_state_o = level_q;
  assign bus.press_o     = press_q;
  assign bus.release_o   = release_q;
  assign bus.long_o      = long_q;
  assign bus.repeat_o    = repeat_q;

endmodule

// File: tb/tb_key_debounce_mc.sv
// Bench for key_debounce_mc: directed scenarios followed by random key
// activity, every cycle compared against a run-length/elapsed-time model.
module tb_key_debounce_mc;

  localparam int CH       = 2;
  localparam int DEB_CNT  = 4;
  localparam int LONG_CNT = 20;
  localparam int REP_CNT  = 8;
  localparam bit ACT_LOW  = 1'b1;
  localparam bit REP_EN   = 1'b1;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;

  logic          sclk = 1'b0;
  logic          rst  = 1'b1;
  logic [CH-1:0] key_r = 2'b11;

  key_debounce_mc_if #(.CH(CH)) bus ();

  assign bus.key_i = key_r;

  key_debounce_mc #(
    .CH(CH), .DEB_CNT(DEB_CNT), .LONG_CNT(LONG_CNT), .REP_CNT(REP_CNT),
    .ACT_LOW(ACT_LOW), .REP_EN(REP_EN)
  ) dut (
    .sclk(sclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 sclk = ~sclk;

  int total = 0;
  int bad   = 0;

  // Reference model: pressed-bit pipeline from the pins, accepted level,
  // length of the current run of disagreeing samples, and time held so far.
  bit            m_pipe1 [CH];
  bit            m_pipe2 [CH];
  bit            m_lvl   [CH];
  int            m_run   [CH];
  int            m_hold  [CH];
  logic [CH-1:0] e_state, e_press, e_rel, e_long, e_rep;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input logic [CH-1:0] kin, input logic rin);
    bit p;
    bit steady;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    for (int c = 0; c < CH; c++) begin
      if (rin) begin
        m_pipe1[c] = 1'b0; m_pipe2[c] = 1'b0; m_lvl[c] = 1'b0;
        m_run[c] = 0; m_hold[c] = 0;
      end else begin
        p = m_pipe2[c];
        m_pipe2[c] = m_pipe1[c];
        m_pipe1[c] = ACT_LOW ? ~kin[c] : kin[c];
        steady = m_lvl[c] && (m_run[c] == 0);
        if (p == m_lvl[c]) begin
          m_run[c] = 0;
        end else begin
          m_run[c]++;
          if (m_run[c] == DEB_CNT) begin
            m_lvl[c]  = p;
            m_run[c]  = 0;
            m_hold[c] = 0;
            if (p) e_press[c] = 1'b1;
            else   e_rel[c]   = 1'b1;
          end
        end
        if (steady && p) begin
          m_hold[c]++;
          if (m_hold[c] == LONG_CNT)
            e_long[c] = 1'b1;
          else if (REP_EN && m_hold[c] > LONG_CNT && ((m_hold[c] - LONG_CNT) % REP_CNT) == 0)
            e_rep[c] = 1'b1;
        end
      end
      e_state[c] = m_lvl[c];
    end
  endtask

  // One clock: advance the model on the edge, then compare all outputs.
  task automatic step();
    @(posedge sclk);
    model_edge(key_r, rst);
    #1;
    check_val("key_state", int'(bus.key_state_o), int'(e_state));
    check_val("press",     int'(bus.press_o),     int'(e_press));
    check_val("release",   int'(bus.release_o),   int'(e_rel));
    check_val("long",      int'(bus.long_o),      int'(e_long));
    check_val("repeat",    int'(bus.repeat_o),    int'(e_rep));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps until the selected pulse appears on channel ch; n = 0 on timeout.
  task automatic wait_pulse(input int ch, input int kind, input int bound, output int n);
    logic [CH-1:0] v;
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      step();
      case (kind)
        K_PRESS: v = bus.press_o;
        K_REL:   v = bus.release_o;
        K_LONG:  v = bus.long_o;
        default: v = bus.repeat_o;
      endcase
      if (v[ch]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int kind;
    #1;
    // Reset with keys released.
    rst = 1'b1; key_r = 2'b11;
    run(3);
    rst = 1'b0;
    run(3);

    // Clean press and release on channel 0.
    key_r[0] = 1'b0;
    wait_pulse(0, K_PRESS, 20, n);
    check_val("t1_press_lat", n, DEB_CNT + 2);
    check_val("t1_state", int'(bus.key_state_o), 1);
    run(5);
    key_r[0] = 1'b1;
    wait_pulse(0, K_REL, 20, n);
    check_val("t1_rel_lat", n, DEB_CNT + 2);
    run(6);

    // Bouncing press: three short low bursts, then a stable low.
    for (int b = 0; b < 3; b++) begin
      key_r[0] = 1'b0; run(3);
      key_r[0] = 1'b1; run(1);
    end
    key_r[0] = 1'b0;
    wait_pulse(0, K_PRESS, 20, n);
    check_val("t2_press_lat", n, DEB_CNT + 2);
    key_r[0] = 1'b1;
    run(12);

    // Long press with repeats on channel 1.
    key_r[1] = 1'b0;
    wait_pulse(1, K_PRESS, 20, n);
    check_val("t3_press_lat", n, DEB_CNT + 2);
    wait_pulse(1, K_LONG, 40, n);
    check_val("t3_long_lat", n, LONG_CNT);
    wait_pulse(1, K_REP, 20, n);
    check_val("t3_rep1_lat", n, REP_CNT);
    wait_pulse(1, K_REP, 20, n);
    check_val("t3_rep2_lat", n, REP_CNT);
    run(14);
    key_r[1] = 1'b1;
    wait_pulse(1, K_REL, 20, n);
    check_val("t3_rel_lat", n, DEB_CNT + 2);
    run(30);

    // Short press: released before the long threshold.
    key_r[0] = 1'b0;
    wait_pulse(0, K_PRESS, 20, n);
    run(10);
    key_r[0] = 1'b1;
    wait_pulse(0, K_REL, 20, n);
    check_val("t4_rel_lat", n, DEB_CNT + 2);
    run(25);

    // Simultaneous press, then release with a bounce on channel 0 only.
    key_r = 2'b00;
    wait_pulse(0, K_PRESS, 20, n);
    check_val("t5_press_lat", n, DEB_CNT + 2);
    check_val("t5_press_both", int'(bus.press_o), 3);
    run(5);
    key_r = 2'b11; run(2);
    key_r = 2'b10; run(1);
    key_r = 2'b11;
    run(20);

    // Reset in the middle of a hold with the key still down.
    key_r[0] = 1'b0;
    wait_pulse(0, K_PRESS, 20, n);
    run(10);
    rst = 1'b1;
    step();
    check_val("t6_rst_state", int'(bus.key_state_o), 0);
    rst = 1'b0;
    wait_pulse(0, K_PRESS, 20, n);
    check_val("t6_press_lat", n, DEB_CNT + 2);
    key_r[0] = 1'b1;
    run(15);

    // Random activity: a bouncy phase, then a slow phase reaching long/repeat.
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < CH; c++) begin
        kind = (i < 1500) ? 6 : 40;
        if ($urandom_range(kind - 1, 0) == 0) key_r[c] = ~key_r[c];
      end
      rst = ($urandom_range(599, 0) == 0) ? 1'b1 : 1'b0;
      step();
    end
    rst = 1'b0;
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
